serdes_lane_aligner: RTL

//  Multi-lane word-alignment and deskew stage between NUM_LANES I_SERDES outputs and O_SERDES inputs.
//  - Per lane: trains on a fixed pattern by pulsing I_SERDES BITSLIP_ADJ until locked.
//  - Buffers post-lock words in per-lane FIFOs and releases them in lockstep across lanes.
//  - Applies a per-word offset, then drives one common LOAD_WORD to all O_SERDES.

---
 rtl/serdes_align_pkg.sv | 20 ++
 rtl/serdes_lane_trainer.sv | 105 ++++++++++
 rtl/serdes_lane_aligner.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/serdes_align_pkg.sv
// rtl/serdes_align_pkg.sv - shared lane states, slip limit helper and error counter width
package serdes_align_pkg;

    localparam int ERR_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEARCH = 3'd1,
        SLIP   = 3'd2,
        SETTLE = 3'd3,
        LOCKED = 3'd4,
        FAIL   = 3'd5
    } lane_state_e;

    // Two full word rotations are enough to visit every bit phase twice.
    function automatic int max_slips(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/serdes_lane_trainer.sv
// rtl/serdes_lane_trainer.sv - per-lane word alignment FSM driving I_SERDES bitslip
module serdes_lane_trainer
    import serdes_align_pkg::*;
#(
    parameter int               WIDTH         = 4,
    parameter logic [WIDTH-1:0] TRAIN_PATTERN = 4'hA,
    parameter int               MATCH_COUNT   = 8,
    parameter int               SLIP_WAIT     = 4
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pll_lock,
    input  logic             train_en,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_valid,
    output logic             bitslip_adj,
    output logic             lane_locked,
    output logic             align_error
);

    localparam int MAX_SLIPS = max_slips(WIDTH);
    localparam int MATCH_W   = $clog2(MATCH_COUNT + 1);
    localparam int SLIP_W    = $clog2(MAX_SLIPS + 1);
    localparam int SETTLE_W  = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

    localparam logic [MATCH_W-1:0]  MATCH_LAST  = MATCH_W'(MATCH_COUNT - 1);
    localparam logic [SLIP_W-1:0]   SLIP_LIMIT  = SLIP_W'(MAX_SLIPS);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SLIP_WAIT - 1);

    lane_state_e         state_q, state_d;
    logic [MATCH_W-1:0]  match_q, match_d;
    logic [SLIP_W-1:0]   slip_q, slip_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            match_q  <= '0;
            slip_q   <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            match_q  <= match_d;
            slip_q   <= slip_d;
            settle_q <= settle_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        match_d     = match_q;
        slip_d      = slip_q;
        settle_d    = settle_q;
        bitslip_adj = (state_q == SLIP);
        lane_locked = (state_q == LOCKED);
        align_error = (state_q == FAIL);

        if (!pll_lock || !train_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SEARCH;
                    match_d = '0;
                    slip_d  = '0;
                end
                SEARCH: begin
                    if (rx_valid) begin
                        if (rx_data == TRAIN_PATTERN) begin
                            if (match_q == MATCH_LAST) begin
                                state_d = LOCKED;
                            end else begin
                                match_d = match_q + 1'b1;
                            end
                        end else begin
                            match_d = '0;
                            state_d = (slip_q == SLIP_LIMIT) ? FAIL : SLIP;
                        end
                    end
                end
                SLIP: begin
                    slip_d   = slip_q + 1'b1;
                    settle_d = '0;
                    state_d  = SETTLE;
                end
                SETTLE: begin
                    // Words arriving while the deserialiser re-frames are untrustworthy.
                    if (settle_q == SETTLE_LAST) begin
                        state_d = SEARCH;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                LOCKED, FAIL: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/serdes_lane_aligner.sv
// rtl/serdes_lane_aligner.sv - multi-lane align/deskew stage; SERDES_ALIGN_ERR_CNT_EN adds err_count
module serdes_lane_aligner
    import serdes_align_pkg::*;
#(
    parameter int               NUM_LANES     = 4,
    parameter int               WIDTH         = 4,
    parameter logic [WIDTH-1:0] TRAIN_PATTERN = 4'hA,
    parameter int               MATCH_COUNT   = 8,
    parameter int               SLIP_WAIT     = 4,
    parameter int               FIFO_DEPTH    = 4,
    parameter int               TX_OFFSET     = 1
)
(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       pll_lock,
    input  logic                       train_en,
    input  logic [NUM_LANES*WIDTH-1:0] rx_data,
    input  logic [NUM_LANES-1:0]       rx_valid,
    output logic [NUM_LANES-1:0]       bitslip_adj,
    output logic [NUM_LANES-1:0]       lane_locked,
    output logic [NUM_LANES-1:0]       align_error,
    output logic                       all_locked,
    output logic [NUM_LANES*WIDTH-1:0] tx_word,
    output logic                       tx_load,
    output logic                       fifo_overflow
`ifdef SERDES_ALIGN_ERR_CNT_EN
    ,
    output logic [NUM_LANES*ERR_CNT_W-1:0] err_count
`endif
);

    localparam int               AW     = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]      FULL_N = (AW+1)'(FIFO_DEPTH);
    localparam logic [WIDTH-1:0] OFFSET = WIDTH'(TX_OFFSET);

    logic [NUM_LANES-1:0]            not_empty;
    logic [NUM_LANES-1:0]            full;
    logic [NUM_LANES-1:0]            wr_req;
    logic [NUM_LANES-1:0]            wr_ok;
    logic [NUM_LANES-1:0]            drop;
    logic [NUM_LANES-1:0][WIDTH-1:0] head;
    logic                            pop;

    assign all_locked = &lane_locked;
    assign pop        = pll_lock & all_locked & (&not_empty);
    assign wr_req     = lane_locked & rx_valid & {NUM_LANES{pll_lock}};
    // A full FIFO still accepts a word when the same edge frees a slot.
    assign wr_ok      = wr_req & (~full | {NUM_LANES{pop}});
    assign drop       = wr_req & ~wr_ok;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [WIDTH-1:0] mem [FIFO_DEPTH];
        logic [AW-1:0]    wr_ptr_q;
        logic [AW-1:0]    rd_ptr_q;
        logic [AW:0]      count_q;

        serdes_lane_trainer #(
            .WIDTH         (WIDTH),
            .TRAIN_PATTERN (TRAIN_PATTERN),
            .MATCH_COUNT   (MATCH_COUNT),
            .SLIP_WAIT     (SLIP_WAIT)
        ) u_trainer (
            .clk         (clk),
            .reset_n     (reset_n),
            .pll_lock    (pll_lock),
            .train_en    (train_en),
            .rx_data     (rx_data[i*WIDTH +: WIDTH]),
            .rx_valid    (rx_valid[i]),
            .bitslip_adj (bitslip_adj[i]),
            .lane_locked (lane_locked[i]),
            .align_error (align_error[i])
        );

        assign not_empty[i] = (count_q != '0);
        assign full[i]      = (count_q == FULL_N);
        assign head[i]      = mem[rd_ptr_q];

        always_ff @(posedge clk) begin
            if (wr_ok[i]) begin
                mem[wr_ptr_q] <= rx_data[i*WIDTH +: WIDTH];
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else if (!pll_lock || !lane_locked[i]) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (wr_ok[i]) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                count_q <= count_q + (AW+1)'(wr_ok[i]) - (AW+1)'(pop);
            end
        end

`ifdef SERDES_ALIGN_ERR_CNT_EN
        logic [ERR_CNT_W-1:0] err_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                err_q <= '0;
            end else if (!pll_lock) begin
                err_q <= '0;
            end else if (drop[i] && (err_q != {ERR_CNT_W{1'b1}})) begin
                err_q <= err_q + 1'b1;
            end
        end

        assign err_count[i*ERR_CNT_W +: ERR_CNT_W] = err_q;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_word       <= '0;
            tx_load       <= 1'b0;
            fifo_overflow <= 1'b0;
        end else begin
            tx_load <= pop;
            if (pop) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    tx_word[i*WIDTH +: WIDTH] <= head[i] + OFFSET;
                end
            end
            if (!pll_lock) begin
                fifo_overflow <= 1'b0;
            end else if (|drop) begin
                fifo_overflow <= 1'b1;
            end
        end
    end

endmodule
